fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the single-cycle and upcoming pipelined MIPS cores. It replaces the free-standing PC plus instruction-memory pairing with a single block. The block holds the program counter and an internal word-addressed instruction memory with a load port. It computes the next PC (sequential, absolute, PC-relative branch, pseudo-direct jump) and presents {pc, instruction} to decode through a valid/ready output register.

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a load port, next-PC selection and a valid/ready output register that
// presents {inst_pc, inst_data} to decode.
module fetch_unit #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [1:0]            redirect_mode,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  inst_ready,
   output logic                  inst_valid,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] pc,
   input  logic                  imem_we,
   input  logic [ADDR_WIDTH-1:0] imem_waddr,
   input  logic [DATA_WIDTH-1:0] imem_wdata
);

   localparam int IDX_WIDTH = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IDX_WIDTH-1:0]  fetch_idx;
   logic [IDX_WIDTH-1:0]  write_idx;
   logic                  advance;
   logic [ADDR_WIDTH-1:0] seq_base;
   logic [ADDR_WIDTH-1:0] rel_offset;
   logic [ADDR_WIDTH-1:0] jump_pc;
   logic [ADDR_WIDTH-1:0] raw_target;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [DATA_WIDTH-1:0] fetch_word;

   // Address bits above the memory index and the byte offset only alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{imem_waddr[ADDR_WIDTH-1:IDX_WIDTH+2], imem_waddr[1:0]};

   assign fetch_idx  = pc[IDX_WIDTH+1:2];
   assign write_idx  = imem_waddr[IDX_WIDTH+1:2];
   assign fetch_word = mem[fetch_idx];
   assign advance    = !inst_valid || inst_ready;

   // Redirect target selection; the branch and jump bases come from the
   // instruction sitting in the output register, valid or not.
   always_comb begin
      seq_base          = inst_pc + ADDR_WIDTH'(4);
      rel_offset        = redirect_target << 2;
      jump_pc           = seq_base;
      jump_pc[27:0]     = {redirect_target[25:0], 2'b00};
      raw_target        = redirect_target;
      case (redirect_mode)
         2'b01:   raw_target = seq_base + rel_offset;
         2'b10:   raw_target = jump_pc;
         default: raw_target = redirect_target;
      endcase
      redirect_pc       = {raw_target[ADDR_WIDTH-1:2], 2'b00};
   end

   // Load port: no reset so programs can be loaded while the core is held in reset.
   always_ff @(posedge clock) begin
      if (imem_we) begin
         mem[write_idx] <= imem_wdata;
      end
   end

   // PC and output register: redirect flushes, otherwise advance or stall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc         <= RESET_PC;
         inst_valid <= 1'b0;
         inst_pc    <= '0;
         inst_data  <= '0;
      end else if (redirect_valid) begin
         pc         <= redirect_pc;
         inst_valid <= 1'b0;
      end else if (advance) begin
         inst_data  <= fetch_word;
         inst_pc    <= pc;
         inst_valid <= 1'b1;
         pc         <= pc + ADDR_WIDTH'(4);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: sequential fetch, backpressure,
// all redirect modes, wrap/aliasing, async reset and write collision.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [1:0]  redirect_mode;
   logic [31:0] redirect_target;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic [31:0] pc;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;

   int vectors    = 0;
   int miscompares = 0;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_mode  (redirect_mode),
      .redirect_target(redirect_target),
      .inst_ready     (inst_ready),
      .inst_valid     (inst_valid),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .pc             (pc),
      .imem_we        (imem_we),
      .imem_waddr     (imem_waddr),
      .imem_wdata     (imem_wdata)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One clock edge, then settle 1 unit before checking or driving.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic redirect(input logic [1:0] mode, input logic [31:0] target);
      redirect_valid  = 1'b1;
      redirect_mode   = mode;
      redirect_target = target;
      applyStimulus();
      redirect_valid  = 1'b0;
   endtask

   task automatic checkInst(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_data);
      checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
      checkOutput({tag, "_pc"}, inst_pc, exp_pc);
      checkOutput({tag, "_data"}, inst_data, exp_data);
   endtask

   // Word at each index: 0x11..0x44 in the first four, 0xA000+i elsewhere.
   function automatic logic [31:0] memWord(input int i);
      return (i < 4) ? 32'(32'h11 * (i + 1)) : 32'(32'hA000 + i);
   endfunction

   initial begin
      reset           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_mode   = 2'b00;
      redirect_target = '0;
      inst_ready      = 1'b1;
      imem_we         = 1'b0;
      imem_waddr      = '0;
      imem_wdata      = '0;

      // Preload the whole memory while held in reset.
      #1;
      for (int i = 0; i < 256; i++) begin
         imem_we    = 1'b1;
         imem_waddr = 32'(i * 4);
         imem_wdata = memWord(i);
         applyStimulus();
      end
      imem_we = 1'b0;
      checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_inst_data", inst_data, 32'h0);

      // Sequential fetch.
      reset = 1'b1;
      applyStimulus();
      checkInst("seq0", 32'h0, 32'h11);
      checkOutput("seq0_next_pc", pc, 32'h4);
      applyStimulus();
      checkInst("seq1", 32'h4, 32'h22);

      // Backpressure for three edges.
      inst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkInst("stall", 32'h4, 32'h22);
         checkOutput("stall_pc", pc, 32'h8);
      end
      inst_ready = 1'b1;
      applyStimulus();
      checkInst("seq2", 32'h8, 32'h33);
      applyStimulus();
      checkInst("seq3", 32'hC, 32'h44);

      // Absolute redirect costs one bubble.
      redirect(2'b00, 32'h20);
      checkOutput("abs_bubble", {31'b0, inst_valid}, 32'd0);
      checkOutput("abs_hold_pc", inst_pc, 32'hC);
      checkOutput("abs_pc", pc, 32'h20);
      applyStimulus();
      checkInst("abs", 32'h20, memWord(8));

      // Relative branch, offset -2 from inst_pc 0x10.
      redirect(2'b00, 32'h10);
      applyStimulus();
      checkInst("pre_rel", 32'h10, memWord(4));
      redirect(2'b01, 32'hFFFF_FFFE);
      checkOutput("rel_pc", pc, 32'hC);
      applyStimulus();
      checkInst("rel", 32'hC, 32'h44);

      // Jump index 0x40 from inst_pc 0x10.
      redirect(2'b00, 32'h10);
      applyStimulus();
      redirect(2'b10, 32'h40);
      checkOutput("jmp_pc", pc, 32'h100);
      applyStimulus();
      checkInst("jmp", 32'h100, memWord(64));

      // Misaligned absolute target and reserved mode.
      redirect(2'b11, 32'h23);
      checkOutput("mis_pc", pc, 32'h20);
      applyStimulus();
      checkInst("mis", 32'h20, memWord(8));

      // Redirect while stalled.
      inst_ready = 1'b0;
      redirect(2'b00, 32'h30);
      checkOutput("stallredir_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("stallredir_hold", inst_pc, 32'h20);
      applyStimulus();
      checkInst("stallredir", 32'h30, memWord(12));
      inst_ready = 1'b1;

      // Index aliasing past the top of memory.
      redirect(2'b00, 32'h3FC);
      applyStimulus();
      checkInst("top", 32'h3FC, memWord(255));
      applyStimulus();
      checkInst("alias", 32'h400, 32'h11);

      // PC wrap at the top of the address space.
      redirect(2'b00, 32'hFFFF_FFFC);
      applyStimulus();
      checkInst("wrap", 32'hFFFF_FFFC, memWord(255));
      checkOutput("wrap_pc", pc, 32'h0);

      // Asynchronous reset between edges, with a redirect pending.
      #2;
      reset           = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h80;
      redirect_mode   = 2'b00;
      #1;
      checkOutput("async_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("async_pc", pc, 32'h0);
      checkOutput("async_data", inst_data, 32'h0);
      applyStimulus();
      checkOutput("async_redir_drop", pc, 32'h0);
      redirect_valid = 1'b0;
      reset          = 1'b1;
      applyStimulus();
      checkInst("post_rst", 32'h0, 32'h11);

      // Write to the index being fetched: old word now, new word on refetch.
      imem_we    = 1'b1;
      imem_waddr = 32'h4;
      imem_wdata = 32'hBEEF;
      applyStimulus();
      imem_we = 1'b0;
      checkInst("coll_old", 32'h4, 32'h22);
      redirect(2'b00, 32'h4);
      applyStimulus();
      checkInst("coll_new", 32'h4, 32'hBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
